// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: FSM states,
// decoded operation codes, divider/stall handshake levels and a priority picker.
package mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DIV_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } mdu_state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_DIV   = 3'd1,
    OP_DIVU  = 3'd2,
    OP_MULT  = 3'd3,
    OP_MULTU = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_t;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic STOP                 = 1'b1;
  localparam logic NO_STOP              = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  // Illegal multi-hot decodes still resolve deterministically: div > divu > mult > multu > mthi > mtlo.
  function automatic md_op_t pick_op(input logic div, input logic divu, input logic mult,
                                     input logic multu, input logic mthi, input logic mtlo);
    md_op_t op;
    if (div)        op = OP_DIV;
    else if (divu)  op = OP_DIVU;
    else if (mult)  op = OP_MULT;
    else if (multu) op = OP_MULTU;
    else if (mthi)  op = OP_MTHI;
    else if (mtlo)  op = OP_MTLO;
    else            op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/mdu_ctrl_hilo_reg.sv
// HI/LO register pair: a 64-bit port for multiply/divide commits and
// independent 32-bit ports for MTHI/MTLO.
module mdu_ctrl_hilo_reg
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we64,
  input  logic [63:0] wdata64,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata32,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // The 64-bit commit takes precedence; the controller never raises both kinds together.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= ZERO_WORD;
      lo <= ZERO_WORD;
    end else if (we64) begin
      hi <= wdata64[63:32];
      lo <= wdata64[31:0];
    end else begin
      if (we_hi) hi <= wdata32;
      if (we_lo) lo <= wdata32;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage. Operands come straight from the
// EX pipeline register, which is held stable while the stall request is up.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        pipe_hold,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_md,
  output logic        busy
);

  mdu_state_t  state;
  logic [3:0]  cnt;
  md_op_t      op;
  logic        is_mul, is_div, mul_done, div_done;
  logic        we64, we_hi, we_lo;
  logic [63:0] wdata64;

  assign op       = pick_op(op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo);
  assign is_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div   = (op == OP_DIV)  || (op == OP_DIVU);
  assign mul_done = (state == ST_MUL_BUSY) && (cnt == 4'(MUL_CYCLES));
  assign div_done = (state == ST_DIV_BUSY) && (div_ready == DIV_RESULT_READY);

  // Sequencer: flush and reset both abandon any operation without committing.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_div) begin
            state <= ST_DIV_BUSY;
          end else if (is_mul) begin
            state <= ST_MUL_BUSY;
            cnt   <= 4'd1;
          end
        end
        ST_MUL_BUSY: begin
          if (mul_done) begin
            state <= ST_DONE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DIV_BUSY: if (div_done) state <= ST_DONE;
        ST_DONE:     if (pipe_hold != STOP) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Operand, handshake and HI/LO write-port steering for the current state.
  always_comb begin
    mul_signed  = 1'b0;
    mul_ina     = ZERO_WORD;
    mul_inb     = ZERO_WORD;
    div_start   = DIV_STOP;
    div_signed  = 1'b0;
    div_opdata1 = ZERO_WORD;
    div_opdata2 = ZERO_WORD;
    we64        = 1'b0;
    wdata64     = mul_result;
    if (state == ST_MUL_BUSY) begin
      mul_signed = op_mult;
      mul_ina    = src_a;
      mul_inb    = src_b;
      we64       = mul_done && !flush;
    end
    if (state == ST_DIV_BUSY) begin
      div_start   = DIV_START;
      div_signed  = op_div;
      div_opdata1 = src_a;
      div_opdata2 = src_b;
      we64        = div_done && !flush;
      wdata64     = div_result;
    end
  end

  assign we_hi       = (state == ST_IDLE) && (op == OP_MTHI) && !flush;
  assign we_lo       = (state == ST_IDLE) && (op == OP_MTLO) && !flush;
  assign div_annul   = flush && (state == ST_DIV_BUSY);
  assign stallreq_md = !flush && (is_mul || is_div) && (state != ST_DONE);
  assign busy        = (state != ST_IDLE);

  mdu_ctrl_hilo_reg u_hilo (
    .clk     (clk),
    .rst     (rst),
    .we64    (we64),
    .wdata64 (wdata64),
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .wdata32 (src_a),
    .hi      (hi_o),
    .lo      (lo_o)
  );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with behavioural multiplier and 33-cycle divider models.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, pipe_hold;
  logic        op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic [31:0] src_a, src_b;
  logic        mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2, hi_o, lo_o;
  logic [63:0] mul_result, div_result;
  logic        stallreq_md, busy;
  logic        force_ready;
  logic [5:0]  dcnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pipe_hold(pipe_hold),
    .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
    .op_mthi(op_mthi), .op_mtlo(op_mtlo), .src_a(src_a), .src_b(src_b),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_opdata1(div_opdata1),
    .div_opdata2(div_opdata2), .div_annul(div_annul), .div_result(div_result),
    .div_ready(div_ready), .hi_o(hi_o), .lo_o(lo_o), .stallreq_md(stallreq_md), .busy(busy)
  );

  // Multiplier model: extend per signedness, keep the low 64 bits.
  logic [63:0] pa, pb;
  always_comb begin
    pa = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'h0, mul_ina};
    pb = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'h0, mul_inb};
    mul_result = pa * pb;
  end

  // Divider model: ready on the 33rd consecutive cycle of div_start.
  always_ff @(posedge clk) begin
    if (rst || !div_start || div_annul) dcnt <= 6'd0;
    else dcnt <= dcnt + 6'd1;
  end
  assign div_ready = (div_start && dcnt == 6'd32) || force_ready;

  logic signed [31:0] sq, sr;
  always_comb begin
    sq = 32'sd0;
    sr = 32'sd0;
    div_result = 64'h0;
    if (div_opdata2 != 32'h0) begin
      if (div_signed) begin
        sq = $signed(div_opdata1) / $signed(div_opdata2);
        sr = $signed(div_opdata1) % $signed(div_opdata2);
        div_result = {sr, sq};
      end else begin
        div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;      // 1 div, 2 divu, 3 mult, 4 multu
    logic [31:0] a, b;
    logic [31:0] ehi, elo;
    logic        esig;
    int          estall;
    int          eds;
  } vec_t;

  task automatic set_op(input logic [2:0] op);
    op_div   = (op == 3'd1);
    op_divu  = (op == 3'd2);
    op_mult  = (op == 3'd3);
    op_multu = (op == 3'd4);
  endtask

  // Issue one op, hold it until the stall drops (DONE), then retire it.
  task automatic run_vec(input int idx, input vec_t v);
    int nstall = 0;
    int nds = 0;
    logic sig = 1'b0;
    logic tmo = 1'b1;
    @(negedge clk);
    set_op(v.op);
    src_a = v.a;
    src_b = v.b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stallreq_md) begin
        tmo = 1'b0;
        break;
      end
      nstall++;
      if (div_start) nds++;
      if (busy) sig = (v.op >= 3'd3) ? mul_signed : div_signed;
      @(negedge clk);
    end
    chk($sformatf("v%0d_timeout", idx), {31'h0, tmo}, 32'h0);
    chk($sformatf("v%0d_stall_cycles", idx), nstall, v.estall);
    chk($sformatf("v%0d_div_start_cycles", idx), nds, v.eds);
    chk($sformatf("v%0d_signed", idx), {31'h0, sig}, {31'h0, v.esig});
    chk($sformatf("v%0d_busy_done", idx), {31'h0, busy}, 32'h1);
    set_op(3'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_busy_idle", idx), {31'h0, busy}, 32'h0);
    chk($sformatf("v%0d_hi", idx), hi_o, v.ehi);
    chk($sformatf("v%0d_lo", idx), lo_o, v.elo);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{3'd3, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 2, 0};
    vecs[1] = '{3'd4, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 2, 0};
    vecs[2] = '{3'd1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 34, 33};
    vecs[3] = '{3'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 33};
    vecs[4] = '{3'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b1, 2, 0};
    vecs[5] = '{3'd2, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, 34, 33};
    vecs[6] = '{3'd1, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b1, 34, 33};

    rst = 1'b1; flush = 1'b0; pipe_hold = 1'b0; force_ready = 1'b0;
    op_mult = 1'b0; op_multu = 1'b0; op_div = 1'b0; op_divu = 1'b0;
    op_mthi = 1'b0; op_mtlo = 1'b0; src_a = 32'h0; src_b = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_stall", {31'h0, stallreq_md}, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_div_start", {31'h0, div_start}, 32'h0);
    chk("rst_div_annul", {31'h0, div_annul}, 32'h0);
    chk("rst_mul_ina", mul_ina, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // MTHI then MTLO on consecutive cycles: no stall, one edge each.
    @(negedge clk);
    op_mthi = 1'b1; src_a = 32'h12345678;
    #1 chk("mthi_stall", {31'h0, stallreq_md}, 32'h0);
    @(negedge clk);
    #1 chk("mthi_hi", hi_o, 32'h12345678);
    op_mthi = 1'b0; op_mtlo = 1'b1; src_a = 32'h9ABCDEF0;
    #1 chk("mtlo_stall", {31'h0, stallreq_md}, 32'h0);
    @(negedge clk);
    #1 chk("mtlo_lo", lo_o, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi_o, 32'h12345678);
    op_mtlo = 1'b0;

    // DIVU 100/7 finishing while the pipe is held: stay in DONE, no restart.
    @(negedge clk);
    op_divu = 1'b1; src_a = 32'd100; src_b = 32'd7;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!stallreq_md) break;
      @(negedge clk);
    end
    chk("hold_reach_done", {31'h0, stallreq_md}, 32'h0);
    pipe_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hold%0d_busy", k), {31'h0, busy}, 32'h1);
      chk($sformatf("hold%0d_div_start", k), {31'h0, div_start}, 32'h0);
      chk($sformatf("hold%0d_stall", k), {31'h0, stallreq_md}, 32'h0);
    end
    pipe_hold = 1'b0; op_divu = 1'b0;
    @(negedge clk);
    #1;
    chk("hold_busy_idle", {31'h0, busy}, 32'h0);
    chk("hold_hi", hi_o, 32'd2);
    chk("hold_lo", lo_o, 32'd14);

    // DIVU flushed at DIV_BUSY cycle 10, then a stray div_ready.
    @(negedge clk);
    op_divu = 1'b1; src_a = 32'd50; src_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_annul", {31'h0, div_annul}, 32'h1);
    chk("flush_stall", {31'h0, stallreq_md}, 32'h0);
    @(negedge clk);
    flush = 1'b0; op_divu = 1'b0;
    #1;
    chk("flush_annul_off", {31'h0, div_annul}, 32'h0);
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_hi", hi_o, 32'd2);
    chk("flush_lo", lo_o, 32'd14);
    force_ready = 1'b1;
    @(negedge clk);
    force_ready = 1'b0;
    #1;
    chk("stray_ready_hi", hi_o, 32'd2);
    chk("stray_ready_lo", lo_o, 32'd14);

    // Reset mid-MULT.
    @(negedge clk);
    op_mult = 1'b1; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    #1 chk("rmul_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op_mult = 1'b0;
    #1;
    chk("rmul_busy_after", {31'h0, busy}, 32'h0);
    chk("rmul_hi", hi_o, 32'h0);
    chk("rmul_lo", lo_o, 32'h0);
    chk("rmul_stall", {31'h0, stallreq_md}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequences the shared multiplier and iterative divider used by the EX stage for MULT/MULTU/DIV/DIVU, and owns the HI/LO register pair (MTHI/MTLO writes, MFHI/MFLO read values).
Raises the EX stall request while an operation is in flight and commits the 64-bit result to HI/LO.
Aborts an in-flight divide on flush.
Sits beside the ALU in EX; the EX pipeline register holds the operands stable while stall is asserted.

Parameters:
MUL_CYCLES, 1, cycles from operand presentation until mul_result is valid (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  abort in-flight op, return to IDLE
pipe_hold  in  1  EX register not advancing this cycle (stall[2] == Stop)
op_mult  in  1  MULT in EX
op_multu  in  1  MULTU in EX
op_div  in  1  DIV in EX
op_divu  in  1  DIVU in EX
op_mthi  in  1  MTHI in EX
op_mtlo  in  1  MTLO in EX
src_a  in  32  rs value
src_b  in  32  rt value
mul_signed  out  1  signed multiply select
mul_ina  out  32  multiplier operand 1
mul_inb  out  32  multiplier operand 2
mul_result  in  64  multiplier product
div_start  out  1  divider start
div_signed  out  1  signed divide select
div_opdata1  out  32  dividend
div_opdata2  out  32  divisor
div_annul  out  1  divider abort
div_result  in  64  {remainder, quotient}
div_ready  in  1  divider result valid
hi_o  out  32  HI register
lo_o  out  32  LO register
stallreq_md  out  1  stall request to the stall controller
busy  out  1  state != IDLE

Behaviour:
- Reset: state = IDLE, cnt = 0, hi_o = lo_o = 0, div_start = 0, div_annul = 0, all operand outputs 0, stallreq_md = 0.
- Op priority when several op_* are high: div > divu > mult > multu > mthi > mtlo. Multiple asserts are illegal, but the priority order is still enforced.
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- IDLE:
  - mult/multu: → MUL_BUSY, cnt = 1.
  - div/divu: → DIV_BUSY.
  - mthi: hi_o <= src_a at the edge; mtlo: lo_o <= src_a. No stall for either.
- MUL_BUSY: mul_ina = src_a, mul_inb = src_b, mul_signed = op_mult.
  - cnt == MUL_CYCLES: {hi_o, lo_o} <= mul_result, → DONE.
  - Otherwise cnt++.
- DIV_BUSY: div_start = 1, div_opdata1 = src_a, div_opdata2 = src_b, div_signed = op_div.
  - On div_ready: hi_o <= div_result[63:32], lo_o <= div_result[31:0], div_start deasserts, → DONE.
  - Divide by zero gets no special handling; whatever the divider returns is committed.
- DONE: → IDLE when pipe_hold = 0. Stays in DONE while pipe_hold = 1, so an op held in EX is not reissued.
- stallreq_md is combinational: 1 when any of mult/multu/div/divu is present and state ∈ {IDLE, MUL_BUSY, DIV_BUSY}; otherwise 0.
  - MULT with MUL_CYCLES = 1: stall in cycles T0 and T1, HI/LO valid at T2.
- Operand outputs are 0 outside their own BUSY state. Operands are driven directly from src_a/src_b; no internal latch.
- flush (any state):
  - → IDLE at the edge; no HI/LO write that cycle.
  - div_annul = 1 combinationally during the flush cycle if state == DIV_BUSY.
  - stallreq_md = 0 during flush.
- flush and div_ready in the same cycle: flush wins, no commit.
- Reset mid-operation: same effect as the reset values; the divider is reset by the same rst.
- busy is 1 in MUL_BUSY, DIV_BUSY and DONE.

Decomposition:
- Shared defines header: state encodings, DivStart/DivStop, DivResultReady/NotReady, Stop/NoStop, ZeroWord (the existing header already holds the last four).
- One sub-module: hilo_reg (HI/LO storage with write-enable and 64-bit/32-bit write ports). The FSM stays in mdu_ctrl.

Test Plan:
- MULT, src_a = 0xFFFFFFFE (-2), src_b = 3, MUL_CYCLES = 1 → stallreq_md high 2 cycles, mul_signed = 1, then hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFA.
- MULTU, src_a = 0xFFFFFFFF, src_b = 2 → mul_signed = 0, hi_o = 0x00000001, lo_o = 0xFFFFFFFE.
- DIV, src_a = 0xFFFFFFF9 (-7), src_b = 2, divider model ready after 33 cycles → div_start held high 33 cycles, div_signed = 1, then hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFD, stallreq_md low in DONE.
- DIVU in progress, flush asserted at cycle 10 → div_annul pulses 1 cycle, state IDLE next cycle, HI/LO unchanged, no commit on a later div_ready.
- DIVU 100/7 completes with pipe_hold = 1 for 3 cycles in DONE → stays DONE, div_start = 0, no restart, hi_o = 2, lo_o = 14.
- MTHI 0x12345678, then next cycle MTLO 0x9ABCDEF0 → no stall, hi_o/lo_o updated one edge later each. rst mid-MULT → everything returns to 0/IDLE next edge.
